// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter and its clock filter.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RTS,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    localparam int         FILTER_LEN      = 8;
    localparam int         FRAME_DATA_BITS = 8;
    localparam logic [3:0] DATA_N_LOAD     = 4'd8;

    // Shift frame: odd parity above the data byte, LSB goes out first.
    function automatic logic [FRAME_DATA_BITS:0] make_frame(input logic [FRAME_DATA_BITS-1:0] d);
        return {~^d, d};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Debounces the raw PS/2 clock line and flags filtered falling edges.
module ps2_clk_filter
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic ps2c_in,
    output logic fall_edge
);

    logic [FILTER_LEN-1:0] filter_reg;
    logic [FILTER_LEN-1:0] filter_next;
    logic                  f_reg;
    logic                  f_next;

    always_comb begin
        filter_next = {ps2c_in, filter_reg[FILTER_LEN-1:1]};
        f_next      = f_reg;
        if (filter_reg == '1)
            f_next = 1'b1;
        else if (filter_reg == '0)
            f_next = 1'b0;
    end

    // All-ones reset keeps an idle-high line from looking like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            filter_reg <= '1;
            f_reg      <= 1'b1;
        end else begin
            filter_reg <= filter_next;
            f_reg      <= f_next;
        end
    end

    assign fall_edge = f_reg & ~f_next;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 8 data bits, odd parity, stop, ACK check.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int RTS_CYCLES     = 5000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err_tick
);

    localparam logic [16:0] RTS_LAST     = 17'(RTS_CYCLES - 1);
    localparam logic [16:0] TIMEOUT_LAST = 17'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [8:0]  b_reg;
    logic [3:0]  n_reg;
    logic [16:0] c_reg;
    logic [1:0]  d_sync;
    logic        fall_edge;

    ps2_clk_filter u_clk_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2c_in   (ps2c_in),
        .fall_edge (fall_edge)
    );

    always_ff @(posedge clk) begin
        if (reset)
            d_sync <= 2'b11;
        else
            d_sync <= {d_sync[0], ps2d_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            b_reg        <= '0;
            n_reg        <= '0;
            c_reg        <= '0;
            ps2c_oe      <= 1'b0;
            ps2d_oe      <= 1'b0;
            tx_done_tick <= 1'b0;
            tx_err_tick  <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            tx_err_tick  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ps2c_oe <= 1'b0;
                    ps2d_oe <= 1'b0;
                    if (wr_ps2) begin
                        b_reg   <= make_frame(din);
                        c_reg   <= '0;
                        ps2c_oe <= 1'b1;
                        state   <= ST_RTS;
                    end
                end
                ST_RTS: begin
                    if (c_reg == RTS_LAST) begin
                        c_reg   <= '0;
                        ps2c_oe <= 1'b0;
                        ps2d_oe <= 1'b1;
                        state   <= ST_START;
                    end else begin
                        c_reg <= c_reg + 17'd1;
                    end
                end
                ST_START, ST_DATA, ST_STOP: begin
                    // A device edge always beats the watchdog on the same cycle.
                    if (fall_edge) begin
                        c_reg <= '0;
                        if (state == ST_START) begin
                            n_reg   <= DATA_N_LOAD;
                            ps2d_oe <= ~b_reg[0];
                            state   <= ST_DATA;
                        end else if (state == ST_DATA) begin
                            if (n_reg == 4'd0) begin
                                ps2d_oe <= 1'b0;
                                state   <= ST_STOP;
                            end else begin
                                b_reg   <= {1'b0, b_reg[8:1]};
                                n_reg   <= n_reg - 4'd1;
                                ps2d_oe <= ~b_reg[1];
                            end
                        end else begin
                            ps2d_oe      <= 1'b0;
                            tx_done_tick <= ~d_sync[1];
                            tx_err_tick  <= d_sync[1];
                            state        <= ST_IDLE;
                        end
                    end else if (c_reg == TIMEOUT_LAST) begin
                        c_reg       <= '0;
                        ps2c_oe     <= 1'b0;
                        ps2d_oe     <= 1'b0;
                        tx_err_tick <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        c_reg <= c_reg + 17'd1;
                    end
                end
                default: begin
                    ps2c_oe <= 1'b0;
                    ps2d_oe <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_idle = (state == ST_IDLE);

endmodule
